fout_ddr_packer: RTL and testbench

FOUT_DDR_PACKER -- requirements
Module: fout_ddr_packer

---
 rtl/fout_ddr_packer.sv | 168 ++++++++++++++++
 tb/tb_fout_ddr_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fout_ddr_packer.sv
// fout_ddr_packer: packs FW-bit feature-out elements into DW-bit DDR write beats.
// Build macro FOUT_RELU_EN enables an element-wise ReLU ahead of the pack register.
module fout_ddr_packer #(
    parameter int FW = 32,
    parameter int DW = 512
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    input  logic [15:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic          data_valid_i,
    input  logic [FW-1:0] data_i,
    output logic          data_ready_o,
    output logic          ddr_valid_o,
    input  logic          ddr_ready_i,
    output logic [DW-1:0] ddr_data_o,
    output logic          ddr_last_o,
    output logic [4:0]    ddr_valid_num_o
);
    localparam int N = DW / FW;
    localparam logic [4:0] N_CNT = 5'(N);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [15:0]   remain_q, remain_d;
    logic [DW-1:0] pack_q, pack_d;
    logic [4:0]    pack_cnt_q, pack_cnt_d;
    logic          pack_last_q, pack_last_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] out_dat_q, out_dat_d;
    logic [4:0]    out_num_q, out_num_d;
    logic          out_last_q, out_last_d;
    logic          out_vld_q, out_vld_d;
    logic          done_q, done_d;

    logic [FW-1:0] elem;
    logic [DW-1:0] beat_dat;
    logic          acc, out_hs, out_free, beat_done, elem_last;

`ifdef FOUT_RELU_EN
    assign elem = data_i[FW-1] ? '0 : data_i;
`else
    assign elem = data_i;
`endif

    // Ready depends only on registers so it never combinationally follows ddr_ready_i.
    assign data_ready_o = (state_q == RUN) && (remain_q != 16'd0) && !pend_q;
    assign acc          = data_valid_i && data_ready_o;
    assign out_hs       = out_vld_q && ddr_ready_i;
    assign out_free     = !out_vld_q || ddr_ready_i;
    assign elem_last    = (remain_q == 16'd1);
    assign beat_done    = (pack_cnt_q == N_CNT - 5'd1) || elem_last;

    always_comb begin
        beat_dat = pack_q;
        for (int k = 0; k < N; k++) begin
            if (pack_cnt_q == 5'(k)) beat_dat[k*FW +: FW] = elem;
        end
    end

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        pack_d      = pack_q;
        pack_cnt_d  = pack_cnt_q;
        pack_last_d = pack_last_q;
        pend_d      = pend_q;
        out_dat_d   = out_dat_q;
        out_num_d   = out_num_q;
        out_last_d  = out_last_q;
        out_vld_d   = out_vld_q;
        done_d      = 1'b0;

        if (out_hs) out_vld_d = 1'b0;

        // A stalled complete beat waits in the pack register until the output frees up.
        if (pend_q && out_free) begin
            out_dat_d   = pack_q;
            out_num_d   = pack_cnt_q;
            out_last_d  = pack_last_q;
            out_vld_d   = 1'b1;
            pack_d      = '0;
            pack_cnt_d  = 5'd0;
            pack_last_d = 1'b0;
            pend_d      = 1'b0;
        end

        if (acc) begin
            remain_d = remain_q - 16'd1;
            if (beat_done && out_free) begin
                out_dat_d   = beat_dat;
                out_num_d   = pack_cnt_q + 5'd1;
                out_last_d  = elem_last;
                out_vld_d   = 1'b1;
                pack_d      = '0;
                pack_cnt_d  = 5'd0;
                pack_last_d = 1'b0;
            end else begin
                pack_d      = beat_dat;
                pack_cnt_d  = pack_cnt_q + 5'd1;
                pack_last_d = elem_last;
                pend_d      = beat_done;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != 16'd0) begin
                        state_d  = RUN;
                        remain_d = len_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (acc && elem_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_hs && out_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            remain_q    <= 16'd0;
            pack_q      <= '0;
            pack_cnt_q  <= 5'd0;
            pack_last_q <= 1'b0;
            pend_q      <= 1'b0;
            out_dat_q   <= '0;
            out_num_q   <= 5'd0;
            out_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            pack_q      <= pack_d;
            pack_cnt_q  <= pack_cnt_d;
            pack_last_q <= pack_last_d;
            pend_q      <= pend_d;
            out_dat_q   <= out_dat_d;
            out_num_q   <= out_num_d;
            out_last_q  <= out_last_d;
            out_vld_q   <= out_vld_d;
            done_q      <= done_d;
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign ddr_valid_o     = out_vld_q;
    assign ddr_data_o      = out_dat_q;
    assign ddr_last_o      = out_last_q;
    assign ddr_valid_num_o = out_num_q;

endmodule

// File: tb/tb_fout_ddr_packer.sv
// Bench for fout_ddr_packer: directed jobs plus random-data/random-handshake jobs scored against a beat model.
module tb_fout_ddr_packer;
    localparam int FW = 32;
    localparam int DW = 512;
    localparam int NE = DW / FW;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          start_i;
    logic [15:0]   len_i;
    logic          busy_o, done_o;
    logic          data_valid_i;
    logic [FW-1:0] data_i;
    logic          data_ready_o;
    logic          ddr_valid_o;
    logic          ddr_ready_i;
    logic [DW-1:0] ddr_data_o;
    logic          ddr_last_o;
    logic [4:0]    ddr_valid_num_o;

    fout_ddr_packer #(.FW(FW), .DW(DW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o),
        .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
        .ddr_valid_o(ddr_valid_o), .ddr_ready_i(ddr_ready_i), .ddr_data_o(ddr_data_o),
        .ddr_last_o(ddr_last_o), .ddr_valid_num_o(ddr_valid_num_o)
    );

    always #5 clk_i = ~clk_i;

    int ntests = 0;
    int nfail  = 0;

    logic [FW-1:0] elems [0:65535];
    logic [DW-1:0] exp_dat[$];
    logic [4:0]    exp_num[$];
    logic          exp_last[$];
    logic [DW-1:0] rx_dat[$];
    logic [4:0]    rx_num[$];
    logic          rx_last[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] relu(input logic [FW-1:0] v);
`ifdef FOUT_RELU_EN
        return v[FW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic fill_seq(input int len);
        for (int i = 0; i < len; i++) elems[i] = FW'(i + 1);
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) elems[i] = $urandom;
    endtask

    // Beat model: chunks of NE elements in arrival order, short last chunk zero-padded.
    task automatic build_model(input int len);
        logic [DW-1:0] beat;
        int cnt;
        exp_dat.delete(); exp_num.delete(); exp_last.delete();
        for (int b = 0; b * NE < len; b++) begin
            beat = '0;
            cnt  = 0;
            for (int k = 0; k < NE && b * NE + k < len; k++) begin
                beat[k*FW +: FW] = relu(elems[b*NE + k]);
                cnt++;
            end
            exp_dat.push_back(beat);
            exp_num.push_back(5'(cnt));
            exp_last.push_back((b + 1) * NE >= len);
        end
    endtask

    task automatic run_job(input int len, input int stall, input bit rnd, input int glitch_at);
        int idx, nb, ndone, cyc, budget, nexp;
        bit prev_hold;
        build_model(len);
        nexp = exp_dat.size();
        rx_dat.delete(); rx_num.delete(); rx_last.delete();
        budget = 8 * len + stall + 200;
        @(negedge clk_i);
        start_i = 1'b1; len_i = 16'(len); data_valid_i = 1'b0; ddr_ready_i = 1'b0;
        @(negedge clk_i);
        idx = 0; nb = 0; ndone = 0; cyc = 0; prev_hold = 1'b0;
        while (ndone == 0 && cyc < budget) begin
            start_i      = (cyc == glitch_at);
            len_i        = (cyc == glitch_at) ? 16'd5 : 16'(len);
            data_valid_i = (idx < len) && (!rnd || $urandom_range(3) != 0);
            data_i       = (idx < len) ? elems[idx] : FW'($urandom);
            ddr_ready_i  = (cyc >= stall) && (!rnd || $urandom_range(2) != 0);
            #1;
            if (cyc == 0) chk("busy_in_job", 32'(busy_o), 32'd1);
            if (stall > 0 && !rnd && cyc == stall)
                chk("accepted_during_stall", 32'(idx), 32'((len < 2 * NE) ? len : 2 * NE));
            if (prev_hold) chk("valid_held", 32'(ddr_valid_o), 32'd1);
            if (data_valid_i && data_ready_o) idx++;
            if (ddr_valid_o) begin
                if (exp_dat.size() == 0) begin
                    chk("extra_beat", 32'(ddr_valid_o), 32'd0);
                end else begin
                    chkw("beat_data", ddr_data_o, exp_dat[0]);
                    chk("beat_num", 32'(ddr_valid_num_o), 32'(exp_num[0]));
                    chk("beat_last", 32'(ddr_last_o), 32'(exp_last[0]));
                    if (ddr_ready_i) begin
                        rx_dat.push_back(ddr_data_o);
                        rx_num.push_back(ddr_valid_num_o);
                        rx_last.push_back(ddr_last_o);
                        void'(exp_dat.pop_front());
                        void'(exp_num.pop_front());
                        void'(exp_last.pop_front());
                        nb++;
                    end
                end
            end
            if (done_o) ndone++;
            prev_hold = ddr_valid_o && !ddr_ready_i;
            cyc++;
            @(negedge clk_i);
        end
        chk("done_seen", 32'(ndone), 32'd1);
        chk("beat_count", 32'(nb), 32'(nexp));
        if (!rnd && stall == 0) chk("full_rate_cycles", 32'(cyc), 32'(len + 2));
        start_i = 1'b0; data_valid_i = 1'b0; ddr_ready_i = 1'b1;
        #1;
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("busy_after_job", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int acc_cnt, guard, vld_seen;
        rstn_i = 1'b0; start_i = 1'b0; len_i = 16'd0;
        data_valid_i = 1'b0; data_i = '0; ddr_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ready", 32'(data_ready_o), 32'd0);
        chk("rst_ddr_valid", 32'(ddr_valid_o), 32'd0);
        chk("rst_ddr_last", 32'(ddr_last_o), 32'd0);
        chkw("rst_ddr_data", ddr_data_o, '0);
        chk("rst_valid_num", 32'(ddr_valid_num_o), 32'd0);
        rstn_i = 1'b1;

        fill_seq(32);
        run_job(32, 0, 1'b0, -1);
        chk("j32_elem1", rx_dat[0][31:0], 32'd1);
        chk("j32_num0", 32'(rx_num[0]), 32'd16);
        chk("j32_num1", 32'(rx_num[1]), 32'd16);
        chk("j32_last0", 32'(rx_last[0]), 32'd0);
        chk("j32_last1", 32'(rx_last[1]), 32'd1);

        fill_seq(20);
        run_job(20, 0, 1'b0, -1);
        chk("j20_num1", 32'(rx_num[1]), 32'd4);
        chk("j20_last1", 32'(rx_last[1]), 32'd1);
        chkw("j20_upper_zero", rx_dat[1] >> 128, '0);

        fill_rand(48);
        run_job(48, 40, 1'b0, -1);

        @(negedge clk_i);
        start_i = 1'b1; len_i = 16'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_busy", 32'(busy_o), 32'd0);
        vld_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i); #1;
            if (i == 0) chk("len0_done_drop", 32'(done_o), 32'd0);
            if (ddr_valid_o) vld_seen++;
        end
        chk("len0_no_beats", 32'(vld_seen), 32'd0);

        fill_rand(37);
        run_job(37, 0, 1'b1, 3);

        for (int j = 0; j < 5; j++) begin
            int l;
            l = $urandom_range(100, 1);
            fill_rand(l);
            run_job(l, $urandom_range(5), 1'b1, -1);
        end

        // Reset after 10 of 16 elements: partial beat must vanish.
        fill_seq(16);
        @(negedge clk_i);
        start_i = 1'b1; len_i = 16'd16;
        @(negedge clk_i);
        start_i = 1'b0; ddr_ready_i = 1'b1;
        acc_cnt = 0; guard = 0;
        while (acc_cnt < 10 && guard < 100) begin
            data_valid_i = 1'b1; data_i = elems[acc_cnt];
            #1;
            if (data_ready_o) acc_cnt++;
            guard++;
            @(negedge clk_i);
        end
        chk("mid_rst_accepted", 32'(acc_cnt), 32'd10);
        data_valid_i = 1'b0; rstn_i = 1'b0;
        @(negedge clk_i); #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_ready", 32'(data_ready_o), 32'd0);
        chk("mid_rst_valid", 32'(ddr_valid_o), 32'd0);
        chk("mid_rst_last", 32'(ddr_last_o), 32'd0);
        chkw("mid_rst_data", ddr_data_o, '0);
        chk("mid_rst_num", 32'(ddr_valid_num_o), 32'd0);
        rstn_i = 1'b1; data_valid_i = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i); #1;
            if (ddr_valid_o || data_ready_o) vld_seen++;
        end
        chk("post_rst_quiet", 32'(vld_seen), 32'd0);
        data_valid_i = 1'b0;
        fill_seq(16);
        run_job(16, 0, 1'b0, -1);
        chk("post_rst_num", 32'(rx_num[0]), 32'd16);
        chk("post_rst_elem1", rx_dat[0][31:0], 32'd1);

        elems[0] = 32'hBF800000;
        elems[1] = 32'h3F800000;
        run_job(2, 0, 1'b0, -1);
`ifdef FOUT_RELU_EN
        chk("relu_neg", rx_dat[0][31:0], 32'h00000000);
`else
        chk("relu_neg", rx_dat[0][31:0], 32'hBF800000);
`endif
        chk("relu_pos", rx_dat[0][63:32], 32'h3F800000);

        fill_rand(65535);
        run_job(65535, 0, 1'b0, -1);
        chk("max_beats", 32'(rx_dat.size()), 32'd4096);
        chk("max_last_num", 32'(rx_num[4095]), 32'd15);
        chk("max_last_flag", 32'(rx_last[4095]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
